// File: rtl/rc6_stream_host.sv
// rc6_stream_host: byte-stream front end for the RC6 core data port; define RC6_TIMEOUT_EN to add the WAIT timeout
module rc6_stream_host #(
   parameter int TIMEOUT = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flag,
   input  logic [7:0]   i_byte,
   input  logic         i_byte_vld,
   output logic         o_byte_rdy,
   output logic [7:0]   o_byte,
   output logic         o_byte_vld,
   input  logic         i_byte_rdy,
   input  logic         i_key_ok,
   output logic         o_core_flag,
   output logic [127:0] o_core_din,
   output logic         o_core_din_en,
   input  logic [127:0] i_core_dout,
   input  logic         i_core_dout_en,
   output logic         o_busy,
   output logic         o_err
);
   typedef enum logic [1:0] {FILL, LOAD, WAIT, DRAIN} state_t;
   state_t state, state_n;
   logic [3:0] cnt;
   logic [127:0] cap;
   logic fill_xfer, drain_xfer, expire;
   assign fill_xfer = state == FILL && i_byte_vld;
   assign drain_xfer = state == DRAIN && i_byte_rdy;
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= FILL;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         FILL: if (fill_xfer && cnt == 4'd15) state_n = LOAD;
         LOAD: if (i_key_ok) state_n = WAIT;
         WAIT: if (i_core_dout_en) state_n = DRAIN; else if (expire) state_n = FILL;
         DRAIN: if (drain_xfer && cnt == 4'd15) state_n = FILL;
         default: state_n = FILL;
      endcase
   end
   always_comb begin
      o_byte_rdy = state == FILL;
      o_byte_vld = state == DRAIN;
      o_core_din_en = state == LOAD && i_key_ok;
      o_byte = state == DRAIN ? cap[{~cnt, 3'b000} +: 8] : 8'h00;
      o_busy = !(state == FILL && cnt == 4'd0);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
         o_core_din <= '0;
         o_core_flag <= 1'b0;
         cap <= '0;
      end else begin
         if (fill_xfer || drain_xfer) cnt <= cnt + 4'd1;
         if (fill_xfer) o_core_din[{~cnt, 3'b000} +: 8] <= i_byte;
         if (fill_xfer && cnt == 4'd0) o_core_flag <= i_flag;
         if (state == WAIT && i_core_dout_en) cap <= i_core_dout;
      end
   end
`ifdef RC6_TIMEOUT_EN
   logic [5:0] wcnt;
   assign expire = state == WAIT && !i_core_dout_en && wcnt == 6'(TIMEOUT - 2);
   always_ff @(posedge i_clk) begin
      if (i_rst || state != WAIT) wcnt <= '0;
      else wcnt <= wcnt + 6'd1;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) o_err <= 1'b0;
      else if (expire) o_err <= 1'b1;
      else if (fill_xfer && cnt == 4'd0) o_err <= 1'b0;
   end
`else
   assign expire = 1'b0;
   assign o_err = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_rc6_stream_host.sv
// tb_rc6_stream_host: directed bench for rc6_stream_host with the core modelled inline
module tb_rc6_stream_host;
   logic         i_clk = 1'b0;
   logic         i_rst, i_flag, i_byte_vld, i_byte_rdy, i_key_ok, i_core_dout_en;
   logic [7:0]   i_byte;
   logic [127:0] i_core_dout;
   logic         o_byte_rdy, o_byte_vld, o_core_flag, o_core_din_en, o_busy, o_err;
   logic [7:0]   o_byte;
   logic [127:0] o_core_din;
   int n_pass = 0;
   int n_tot = 0;
   logic [127:0] ct;
   logic [127:0] pat;
   rc6_stream_host dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flag(i_flag), .i_byte(i_byte), .i_byte_vld(i_byte_vld),
      .o_byte_rdy(o_byte_rdy), .o_byte(o_byte), .o_byte_vld(o_byte_vld), .i_byte_rdy(i_byte_rdy),
      .i_key_ok(i_key_ok), .o_core_flag(o_core_flag), .o_core_din(o_core_din),
      .o_core_din_en(o_core_din_en), .i_core_dout(i_core_dout), .i_core_dout_en(i_core_dout_en),
      .o_busy(o_busy), .o_err(o_err)
   );
   always #5 i_clk = ~i_clk;
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tot++;
      if (got !== exp) $display("FAIL %s got %h exp %h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic check_reset();
      check("rst_byte_rdy", o_byte_rdy, 1);
      check("rst_byte", o_byte, 0);
      check("rst_byte_vld", o_byte_vld, 0);
      check("rst_core_flag", o_core_flag, 0);
      check("rst_core_din", o_core_din, 0);
      check("rst_din_en", o_core_din_en, 0);
      check("rst_busy", o_busy, 0);
      check("rst_err", o_err, 0);
   endtask
   task automatic feed(input logic flag, input logic [127:0] blk);
      for (int k = 0; k < 16; k++) begin
         i_byte_vld = 1'b1;
         i_byte = blk[127-8*k -: 8];
         i_flag = k == 0 ? flag : ~flag;
         #1;
         check("fill_rdy", o_byte_rdy, 1);
         step();
      end
      i_byte_vld = 1'b0;
      i_flag = 1'b0;
      check("packed_din", o_core_din, blk);
      check("latched_flag", o_core_flag, flag);
      check("load_rdy_low", o_byte_rdy, 0);
   endtask
   task automatic run_core(input logic [127:0] resp, input logic flag);
      check("din_en_pulse", o_core_din_en, 1);
      step();
      check("din_en_single", o_core_din_en, 0);
      check("wait_busy", o_busy, 1);
      repeat (18) step();
      check("no_early_vld", o_byte_vld, 0);
      check("wait_flag", o_core_flag, flag);
      i_core_dout = resp;
      i_core_dout_en = 1'b1;
      step();
      i_core_dout_en = 1'b0;
      i_core_dout = ~resp;
   endtask
   task automatic drain(input logic [127:0] exp, input logic bp);
      int j = 0;
      for (int c = 0; c < 40 && j < 16; c++) begin
         i_byte_rdy = bp ? c % 2 == 0 : 1'b1;
         #1;
         check("drain_vld", o_byte_vld, 1);
         check("drain_byte", o_byte, exp[127-8*j -: 8]);
         check("drain_rdy_low", o_byte_rdy, 0);
         if (i_byte_rdy) j++;
         step();
      end
      i_byte_rdy = 1'b1;
      check("drain_count", j, 16);
      check("fill_resume", o_byte_rdy, 1);
      check("drain_done_vld", o_byte_vld, 0);
      check("idle", o_busy, 0);
   endtask
   initial begin
      ct = 128'h8fc3a53656b1f778c129df4e9848a41e;
      pat = 128'h000102030405060708090a0b0c0d0e0f;
      i_rst = 1'b1; i_flag = 1'b0; i_byte = 8'h00; i_byte_vld = 1'b0; i_byte_rdy = 1'b1;
      i_key_ok = 1'b1; i_core_dout_en = 1'b0; i_core_dout = '0;
      step();
      step();
      i_rst = 1'b0;
      check_reset();
      i_core_dout_en = 1'b1;
      i_core_dout = 128'hdead;
      step();
      i_core_dout_en = 1'b0;
      check("stray_dout_en", o_busy, 0);
      feed(1'b1, 128'h0);
      run_core(ct, 1'b1);
      drain(ct, 1'b0);
      feed(1'b0, ct);
      run_core(128'h0, 1'b0);
      drain(128'h0, 1'b0);
      check("dec_flag_end", o_core_flag, 0);
      i_key_ok = 1'b0;
      feed(1'b1, pat);
      for (int c = 0; c < 10; c++) begin
         check("key_wait_din_en", o_core_din_en, 0);
         check("key_wait_din", o_core_din, pat);
         check("key_wait_rdy", o_byte_rdy, 0);
         step();
      end
      i_key_ok = 1'b1;
      #1;
      run_core(~pat, 1'b1);
      drain(~pat, 1'b1);
      for (int k = 0; k < 8; k++) begin
         i_byte_vld = 1'b1;
         i_byte = 8'h5a;
         i_flag = 1'b1;
         step();
      end
      i_byte_vld = 1'b0;
      check("mid_busy", o_busy, 1);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      check_reset();
      feed(1'b1, 128'h0);
      run_core(ct, 1'b1);
      drain(ct, 1'b0);
`ifdef RC6_TIMEOUT_EN
      feed(1'b1, pat);
      check("to_pulse", o_core_din_en, 1);
      check("to_err_pulse", o_err, 0);
      repeat (31) step();
      check("to_err_early", o_err, 0);
      check("to_busy_early", o_busy, 1);
      step();
      check("to_err_set", o_err, 1);
      check("to_fill", o_byte_rdy, 1);
      check("to_idle", o_busy, 0);
      i_byte_vld = 1'b1;
      i_byte = 8'h11;
      step();
      i_byte_vld = 1'b0;
      check("to_err_clear", o_err, 0);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
`endif
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
